// File: rtl/rvj1_dram_wb_bridge_pkg.sv
// ----------------------------------------------------------------------------
// rvj1_pkg
// Shared types and constants for the jedro_1 data-memory to Wishbone bridge.
//   bridge_state_e : bridge FSM states
//   DEF_ADDR_BASE  : default base address of the legal data window
//   DEF_ADDR_MASK  : default compare mask for the data window
//   sel_w()        : byte-select width for a given data width
// ----------------------------------------------------------------------------
package rvj1_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS      = 2'd1,
    RESP_OK  = 2'd2,
    RESP_ERR = 2'd3
  } bridge_state_e;

  localparam logic [31:0] DEF_ADDR_BASE = 32'h3000_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFFFF_0000;

  // One byte select per byte lane of the data bus.
  function automatic int sel_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/rvj1_dram_wb_bridge_if.sv
// ----------------------------------------------------------------------------
// rvj1_dram_wb_bridge_if
// Bundles the core-side dram_* strobe port and the Wishbone classic port.
//   master : the bridge's view (takes core requests, masters Wishbone)
//   slave  : the environment's view (core drives requests, slave answers bus)
// Parameters AW/DW must match the bridge instance using the interface.
// ----------------------------------------------------------------------------
interface rvj1_dram_wb_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import rvj1_pkg::*;

  localparam int SEL_W = sel_w(DW);

  // core data-memory port
  logic [SEL_W-1:0] dram_we;
  logic             dram_stb;
  logic [AW-1:0]    dram_addr;
  logic [DW-1:0]    dram_wdata;
  logic [DW-1:0]    dram_rdata;
  logic             dram_ack;
  logic             dram_err;

  // Wishbone classic master port
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [SEL_W-1:0] wbm_sel_o;
  logic [AW-1:0]    wbm_adr_o;
  logic [DW-1:0]    wbm_dat_o;
  logic [DW-1:0]    wbm_dat_i;
  logic             wbm_ack_i;
  logic             wbm_err_i;

  modport master (
    input  dram_we, dram_stb, dram_addr, dram_wdata,
    output dram_rdata, dram_ack, dram_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    output dram_we, dram_stb, dram_addr, dram_wdata,
    input  dram_rdata, dram_ack, dram_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );

endinterface

// File: rtl/rvj1_dram_wb_bridge_sat_counter.sv
// ----------------------------------------------------------------------------
// rvj1_sat_counter
// Up-counter that clears on demand and sticks at all ones instead of wrapping.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   clear         : synchronous clear (wins over inc)
//   inc           : count up by one when not saturated
//   count         : current value
//   sat           : terminal-count flag, high when count is all ones
// ----------------------------------------------------------------------------
module rvj1_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  assign sat = (count == '1);

  // Clear has priority; once at all ones further increments are dropped so
  // the value never wraps back to zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rvj1_dram_wb_bridge.sv
// ----------------------------------------------------------------------------
// rvj1_dram_wb_bridge
// Turns single-cycle jedro_1 dram_* strobes into registered Wishbone classic
// cycles. Requests outside the data window are refused without touching the
// bus; a silent slave is cut off by a watchdog; every error response bumps a
// saturating error counter. One transaction is outstanding at a time.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   bus           : core strobe port + Wishbone master port (master modport)
//   err_count_o   : saturating count of dram_err pulses
//   busy_o        : high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module rvj1_dram_wb_bridge
  import rvj1_pkg::*;
#(
  parameter int            AW             = 32,
  parameter int            DW             = 32,
  parameter logic [AW-1:0] ADDR_BASE      = AW'(DEF_ADDR_BASE),
  parameter logic [AW-1:0] ADDR_MASK      = AW'(DEF_ADDR_MASK),
  parameter int            TIMEOUT_CYCLES = 255,
  parameter int            CNT_W          = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  rvj1_dram_wb_bridge_if.master bus,
  output logic [CNT_W-1:0]      err_count_o,
  output logic                  busy_o
);

  localparam int SEL_W = sel_w(DW);

  bridge_state_e    state_q, state_d;
  logic [AW-1:0]    addr_q;
  logic [SEL_W-1:0] we_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata_q;
  logic             in_window;
  logic [CNT_W-1:0] tmo_count;
  logic             tmo_sat;
  logic             err_sat;
  logic             timed_out;

  assign in_window = ((bus.dram_addr & ADDR_MASK) == ADDR_BASE);

  // The saturation flag can only be reached if TIMEOUT_CYCLES is set out of
  // range; treating it as a timeout guarantees the bus is always released.
  assign timed_out = (tmo_count == CNT_W'(TIMEOUT_CYCLES - 1)) || tmo_sat;

  // Watchdog: held at zero outside BUS so it starts from zero on entry and
  // counts every cycle the slave keeps us waiting.
  rvj1_sat_counter #(.CNT_W(CNT_W)) u_tmo_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear  (state_q != BUS),
    .inc    (state_q == BUS),
    .count  (tmo_count),
    .sat    (tmo_sat)
  );

  // Error counter: one increment per dram_err pulse, never cleared except by
  // reset.
  rvj1_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear  (1'b0),
    .inc    ((state_q == RESP_ERR) && !err_sat),
    .count  (err_count_o),
    .sat    (err_sat)
  );

  // State register. Reset drops straight to IDLE, which also removes cyc/stb
  // asynchronously and discards any in-flight request without a response.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture and read-data return. The request is latched on every
  // accepted strobe so the bus sees stable values during BUS; read data is
  // only overwritten by a successful read, so it survives writes and errors.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && bus.dram_stb) begin
        addr_q  <= bus.dram_addr;
        we_q    <= bus.dram_we;
        wdata_q <= bus.dram_wdata;
      end
      if (state_q == BUS && bus.wbm_ack_i && !bus.wbm_err_i && we_q == '0) begin
        rdata_q <= bus.wbm_dat_i;
      end
    end
  end

  // Next state and the state-decoded outputs. Since everything is decoded
  // from the state register, cyc/stb/ack/err are all registered timing. In
  // BUS a slave error outranks an ack, and the watchdog only fires when the
  // slave has said nothing this cycle. Strobes outside IDLE are ignored.
  always_comb begin
    state_d       = state_q;
    bus.wbm_cyc_o = 1'b0;
    bus.wbm_stb_o = 1'b0;
    bus.wbm_we_o  = 1'b0;
    bus.wbm_sel_o = '0;
    bus.dram_ack  = 1'b0;
    bus.dram_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dram_stb) begin
          state_d = in_window ? BUS : RESP_ERR;
        end
      end
      BUS: begin
        bus.wbm_cyc_o = 1'b1;
        bus.wbm_stb_o = 1'b1;
        bus.wbm_we_o  = |we_q;
        bus.wbm_sel_o = (we_q == '0) ? '1 : we_q;
        if (bus.wbm_err_i) begin
          state_d = RESP_ERR;
        end else if (bus.wbm_ack_i) begin
          state_d = RESP_OK;
        end else if (timed_out) begin
          state_d = RESP_ERR;
        end
      end
      RESP_OK: begin
        bus.dram_ack = 1'b1;
        state_d      = IDLE;
      end
      RESP_ERR: begin
        bus.dram_err = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.wbm_adr_o  = addr_q;
  assign bus.wbm_dat_o  = wdata_q;
  assign bus.dram_rdata = rdata_q;
  assign busy_o         = (state_q != IDLE);

  // A new strobe before the previous request was answered means the core
  // broke the one-outstanding rule; the bridge drops it, this makes it loud.
  a_no_stb_while_busy: assert property (
    @(posedge clk_i) disable iff (!rstn_i) !(bus.dram_stb && busy_o));

  a_ack_err_exclusive: assert property (
    @(posedge clk_i) disable iff (!rstn_i) !(bus.dram_ack && bus.dram_err));

endmodule

// File: tb/tb_rvj1_dram_wb_bridge.sv
// ----------------------------------------------------------------------------
// tb_rvj1_dram_wb_bridge
// Self-checking bench for rvj1_dram_wb_bridge (TIMEOUT_CYCLES=4, CNT_W=8).
// Each request pushes its expected response onto a scoreboard queue; a
// monitor pops and compares whenever dram_ack or dram_err shows up.
// ----------------------------------------------------------------------------
module tb_rvj1_dram_wb_bridge;
  import rvj1_pkg::*;

  localparam int TMO   = 4;
  localparam int CNT_W = 8;

  localparam int M_ACK    = 0;
  localparam int M_ERR    = 1;
  localparam int M_BOTH   = 2;
  localparam int M_SILENT = 3;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic             clk_i;
  logic             rstn_i;
  logic [CNT_W-1:0] err_count_o;
  logic             busy_o;

  exp_t        sb[$];
  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [31:0] model_rdata  = 32'h0;
  int          model_cnt    = 0;

  rvj1_dram_wb_bridge_if #(.AW(32), .DW(32)) bus ();

  rvj1_dram_wb_bridge #(
    .AW             (32),
    .DW             (32),
    .ADDR_BASE      (32'h3000_0000),
    .ADDR_MASK      (32'hFFFF_0000),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .bus         (bus),
    .err_count_o (err_count_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard stop in case something wedges beyond every per-transaction bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (bus.dram_ack || bus.dram_err) begin
      checkOutput("ack_err_exclusive", 32'(bus.dram_ack & bus.dram_err), 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_response", 32'({bus.dram_ack, bus.dram_err}), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("resp_is_err", 32'(bus.dram_err), 32'(e.err));
        checkOutput("dram_rdata", bus.dram_rdata, e.rdata);
      end
    end
  end

  // Drives one core request and plays the Wishbone slave for it. The slave
  // answers (per mode) on bus cycle waits+1; cyc-high cycles, response
  // latency, Wishbone qualifiers and the error count are checked here.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] we,
                               input logic [31:0] wdata, input int mode,
                               input int waits, input logic [31:0] sdata);
    logic in_win;
    logic exp_err;
    int   exp_cyc;
    int   exp_lat;
    int   cyc_cnt;
    int   stb_cnt;
    int   resp_at;
    in_win  = ((addr & 32'hFFFF_0000) == 32'h3000_0000);
    exp_err = !in_win || (mode != M_ACK);
    exp_cyc = !in_win ? 0 : ((mode == M_SILENT) ? TMO : waits + 1);
    exp_lat = (exp_cyc == 0) ? 1 : exp_cyc + 1;
    if (!exp_err && we == 4'b0000) model_rdata = sdata;
    if (exp_err && model_cnt < 255) model_cnt++;
    sb.push_back('{err: exp_err, rdata: model_rdata});

    bus.dram_stb   = 1'b1;
    bus.dram_addr  = addr;
    bus.dram_we    = we;
    bus.dram_wdata = wdata;
    cyc_cnt = 0;
    stb_cnt = 0;
    resp_at = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      bus.dram_stb  = 1'b0;
      bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
      bus.wbm_dat_i = ~sdata;
      if (bus.wbm_stb_o) stb_cnt++;
      if (bus.wbm_cyc_o) begin
        cyc_cnt++;
        if (cyc_cnt == 1) begin
          checkOutput("wb_sel", 32'(bus.wbm_sel_o), 32'((we == 4'b0000) ? 4'hF : we));
          checkOutput("wb_we", 32'(bus.wbm_we_o), 32'(|we));
          checkOutput("wb_adr", bus.wbm_adr_o, addr);
          if (we != 4'b0000) checkOutput("wb_dat", bus.wbm_dat_o, wdata);
        end
        if (mode != M_SILENT && cyc_cnt == waits + 1) begin
          bus.wbm_dat_i = sdata;
          bus.wbm_ack_i = (mode == M_ACK) || (mode == M_BOTH);
          bus.wbm_err_i = (mode == M_ERR) || (mode == M_BOTH);
        end
      end
      if (bus.dram_ack || bus.dram_err) begin
        resp_at = c;
        break;
      end
    end
    checkOutput("cyc_cycles", 32'(cyc_cnt), 32'(exp_cyc));
    checkOutput("stb_cycles", 32'(stb_cnt), 32'(exp_cyc));
    checkOutput("resp_latency", 32'(resp_at), 32'(exp_lat));
    step();
    checkOutput("busy_after", 32'(busy_o), 32'd0);
    checkOutput("err_count", 32'(err_count_o), 32'(model_cnt));
  endtask

  initial begin
    logic [31:0] a;
    rstn_i         = 1'b0;
    bus.dram_stb   = 1'b0;
    bus.dram_we    = 4'b0000;
    bus.dram_addr  = 32'h0;
    bus.dram_wdata = 32'h0;
    bus.wbm_dat_i  = 32'h0;
    bus.wbm_ack_i  = 1'b0;
    bus.wbm_err_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    step();

    $display("[TB] reset state");
    checkOutput("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_err_count", 32'(err_count_o), 32'd0);
    checkOutput("rst_rdata", bus.dram_rdata, 32'd0);
    checkOutput("rst_sel", 32'(bus.wbm_sel_o), 32'd0);

    $display("[TB] zero-wait read, 3-wait byte write, window miss");
    applyStimulus(32'h3000_0010, 4'b0000, 32'h0, M_ACK, 0, 32'hDEAD_BEEF);
    applyStimulus(32'h3000_0020, 4'b0100, 32'h00AA_0000, M_ACK, 3, 32'h1111_1111);
    applyStimulus(32'h2000_0000, 4'b0000, 32'h0, M_ACK, 0, 32'h2222_2222);

    $display("[TB] timeout then late ack");
    applyStimulus(32'h3000_0030, 4'b0000, 32'h0, M_SILENT, 0, 32'h3333_3333);
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'hFFFF_FFFF;
    step();
    bus.wbm_ack_i = 1'b0;
    step();
    checkOutput("late_ack_busy", 32'(busy_o), 32'd0);
    checkOutput("late_ack_rdata", bus.dram_rdata, model_rdata);

    $display("[TB] ack+err together, slave error, 1-wait read");
    applyStimulus(32'h3000_0044, 4'b0000, 32'h0, M_BOTH, 1, 32'h1234_5678);
    applyStimulus(32'h3000_0048, 4'b1111, 32'h5555_AAAA, M_ERR, 2, 32'h0);
    applyStimulus(32'h3000_FFFC, 4'b0000, 32'h0, M_ACK, 1, 32'hCAFE_F00D);

    $display("[TB] reset in the middle of a bus cycle");
    bus.dram_stb  = 1'b1;
    bus.dram_addr = 32'h3000_0040;
    bus.dram_we   = 4'b0000;
    step();
    bus.dram_stb = 1'b0;
    step();
    checkOutput("pre_rst_cyc", 32'(bus.wbm_cyc_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    checkOutput("mid_rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    checkOutput("mid_rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    model_cnt   = 0;
    model_rdata = 32'h0;
    repeat (2) step();
    rstn_i = 1'b1;
    repeat (5) step();
    checkOutput("post_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("post_rst_err_count", 32'(err_count_o), 32'd0);
    applyStimulus(32'h3000_0050, 4'b0000, 32'h0, M_ACK, 0, 32'h0BAD_C0DE);

    $display("[TB] 256 window misses saturate the error counter");
    for (int i = 0; i < 256; i++) begin
      a = $urandom;
      if (a[31:16] == 16'h3000) a = a ^ 32'h8000_0000;
      applyStimulus(a, 4'($urandom_range(0, 15)), $urandom, M_ACK, 0, 32'h0);
    end
    checkOutput("err_count_saturated", 32'(err_count_o), 32'd255);

    repeat (3) step();
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
